ads1115_i2c_target: RTL and testbench

Synthesizable I2C target that emulates the ADS1115 register interface at a fixed 7-bit address. It is the bus-side counterpart of our ADS1115 I2C master: it decodes START/STOP, the address byte, the pointer byte and 16-bit register writes, and serves 16-bit register reads. It sits in the FPGA-only test/loopback build in place of the real ADC so the master can be exercised end to end. Conversion data comes from a parallel input, for example a test pattern or ADC model.

---
 rtl/ads1115_pkg.sv | 40 ++++
 rtl/ads1115_i2c_target_sync.sv | 48 ++++
 rtl/ads1115_i2c_target.sv | 238 +++++++++++++++++++++++
 tb/tb_ads1115_i2c_target.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads1115_pkg.sv
// Shared types and constants for the ADS1115 register-interface I2C target.
// Holds the bus FSM encoding, pointer codes and register reset values.
package ads1115_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        MACK      = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    localparam logic [15:0] CONFIG_RST = 16'h8583;
    localparam logic [15:0] LO_RST     = 16'h8000;
    localparam logic [15:0] HI_RST     = 16'h7FFF;

    function automatic logic [15:0] select_reg(input logic [1:0]  ptr,
                                               input logic [15:0] conv,
                                               input logic [15:0] cfg,
                                               input logic [15:0] lo,
                                               input logic [15:0] hi);
        case (ptr)
            PTR_CONV: return conv;
            PTR_CFG:  return cfg;
            PTR_LO:   return lo;
            default:  return hi;
        endcase
    endfunction

endpackage

// File: rtl/ads1115_i2c_target_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious events.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o       = sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA change near an SCL edge is not misread
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/ads1115_i2c_target.sv
// ADS1115 register-interface emulator: I2C target FSM, pointer and register file.
// Bits are sampled on SCL rise; SDA drive changes only on SCL fall.
module ads1115_i2c_target
    import ads1115_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'b1001000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] conv_data,
    input  logic        conv_valid,
    output logic [15:0] config_reg,
    output logic [15:0] lo_thresh,
    output logic [15:0] hi_thresh,
    output logic [1:0]  pointer_reg,
    output logic        cfg_write,
    output logic [3:0]  state_check
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        pull_q, pull_d;
    logic [1:0]  pointer_q, pointer_d;
    logic        rw_q, rw_d;
    logic        byte_sel_q, byte_sel_d;
    logic [7:0]  wmsb_q, wmsb_d;
    logic        nack_q, nack_d;
    logic [15:0] conv_q, conv_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] config_q, config_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] hi_q, hi_d;
    logic        cfg_write_q, cfg_write_d;
    logic [15:0] rd_word;
    logic [7:0]  rd_byte;

    assign rd_word = select_reg(pointer_q, snap_q, config_q, lo_q, hi_q);
    assign rd_byte = byte_sel_q ? rd_word[7:0] : rd_word[15:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            pull_q      <= 1'b0;
            pointer_q   <= PTR_CONV;
            rw_q        <= 1'b0;
            byte_sel_q  <= 1'b0;
            wmsb_q      <= 8'd0;
            nack_q      <= 1'b0;
            conv_q      <= 16'd0;
            snap_q      <= 16'd0;
            config_q    <= CONFIG_RST;
            lo_q        <= LO_RST;
            hi_q        <= HI_RST;
            cfg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pull_q      <= pull_d;
            pointer_q   <= pointer_d;
            rw_q        <= rw_d;
            byte_sel_q  <= byte_sel_d;
            wmsb_q      <= wmsb_d;
            nack_q      <= nack_d;
            conv_q      <= conv_d;
            snap_q      <= snap_d;
            config_q    <= config_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cfg_write_q <= cfg_write_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pull_d      = pull_q;
        pointer_d   = pointer_q;
        rw_d        = rw_q;
        byte_sel_d  = byte_sel_q;
        wmsb_d      = wmsb_q;
        nack_d      = nack_q;
        conv_d      = conv_valid ? conv_data : conv_q;
        snap_d      = snap_q;
        config_d    = config_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cfg_write_d = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            pull_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            pull_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_d = ADDR_ACK;
                                pull_d  = 1'b1;
                                rw_d    = shift_q[0];
                                snap_d  = conv_d;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            state_d   = PTR_ACK;
                            pull_d    = 1'b1;
                            pointer_d = shift_q[1:0];
                        end else begin
                            state_d = WDATA_ACK;
                            pull_d  = 1'b1;
                            if (!byte_sel_q) begin
                                wmsb_d = shift_q;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d    = RDATA;
                            shift_d    = rd_word[15:8];
                            pull_d     = ~rd_word[15];
                            byte_sel_d = 1'b1;
                        end else begin
                            state_d    = PTR;
                            pull_d     = 1'b0;
                            byte_sel_d = 1'b0;
                        end
                    end
                end
                PTR_ACK: begin
                    if (scl_fall) begin
                        state_d    = WDATA;
                        pull_d     = 1'b0;
                        byte_sel_d = 1'b0;
                    end
                end
                WDATA_ACK: begin
                    // shift_q still holds the LSB here: nothing shifts during an ACK clock
                    if (scl_fall) begin
                        state_d    = WDATA;
                        pull_d     = 1'b0;
                        byte_sel_d = ~byte_sel_q;
                        if (byte_sel_q) begin
                            case (pointer_q)
                                PTR_CFG: begin
                                    config_d    = {wmsb_q, shift_q};
                                    cfg_write_d = 1'b1;
                                end
                                PTR_LO: begin
                                    lo_d        = {wmsb_q, shift_q};
                                    cfg_write_d = 1'b1;
                                end
                                PTR_HI: begin
                                    hi_d        = {wmsb_q, shift_q};
                                    cfg_write_d = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = MACK;
                            pull_d    = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            pull_d  = ~shift_q[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (nack_q) begin
                            state_d = IGNORE;
                        end else begin
                            state_d    = RDATA;
                            shift_d    = rd_byte;
                            pull_d     = ~rd_byte[7];
                            byte_sel_d = ~byte_sel_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA         = pull_q ? 1'b0 : 1'bz;
    assign config_reg  = config_q;
    assign lo_thresh   = lo_q;
    assign hi_thresh   = hi_q;
    assign pointer_reg = pointer_q;
    assign cfg_write   = cfg_write_q;
    assign state_check = state_q;

endmodule

// File: tb/tb_ads1115_i2c_target.sv
// Self-checking bench for ads1115_i2c_target: bit-banged I2C master plus a
// queue of expected ACKs/read bytes compared as the bus returns them.
module tb_ads1115_i2c_target;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        master_low;
    logic [15:0] conv_data;
    logic        conv_valid;
    wire         sda_bus;
    logic [15:0] config_reg, lo_thresh, hi_thresh;
    logic [1:0]  pointer_reg;
    logic        cfg_write;
    logic [3:0]  state_check;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expq[$];
    int          cfg_pulses = 0;
    int          cfg_high = 0;
    logic        cfg_prev = 1'b0;
    logic        pull_seen = 1'b0;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = master_low ? 1'b0 : 1'bz;

    ads1115_i2c_target #(.TARGET_ADDR(7'b1001000), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .SCL        (scl),
        .SDA        (sda_bus),
        .conv_data  (conv_data),
        .conv_valid (conv_valid),
        .config_reg (config_reg),
        .lo_thresh  (lo_thresh),
        .hi_thresh  (hi_thresh),
        .pointer_reg(pointer_reg),
        .cfg_write  (cfg_write),
        .state_check(state_check)
    );

    // Track cfg_write pulses and any SDA pull-down coming from the target
    always @(negedge clk) begin
        if (cfg_write) cfg_high++;
        if (cfg_write && !cfg_prev) cfg_pulses++;
        cfg_prev = cfg_write;
        if (sda_bus === 1'b0 && !master_low) pull_seen = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bus-level master primitives
    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        master_low = 1'b0; scl = 1'b1; qwait();
        master_low = 1'b1; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic bus_rstart();
        master_low = 1'b0; qwait();
        scl = 1'b1; qwait();
        master_low = 1'b1; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        master_low = 1'b1; qwait();
        scl = 1'b1; qwait();
        master_low = 1'b0; qwait();
    endtask

    task automatic write_bit(input logic b);
        master_low = ~b; qwait();
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        master_low = 1'b0; qwait();
        scl = 1'b1; qwait();
        b = sda_bus; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // Send a byte, expecting the given ACK level, and score it
    task automatic applyStimulus(input logic [7:0] d, input logic exp_ack, input string name);
        logic       ack;
        logic [7:0] e;
        expq.push_back({7'd0, exp_ack});
        write_byte(d, ack);
        e = expq.pop_front();
        checks++;
        if ({7'd0, ack} !== e) begin
            errors++;
            $display("[TB] FAIL %s: ack got %b want %b", name, ack, e[0]);
        end
    endtask

    task automatic test_reset();
        checks++; if (config_reg !== 16'h8583) begin errors++; $display("[TB] FAIL rst_config: got %h want 8583", config_reg); end
        checks++; if (lo_thresh !== 16'h8000) begin errors++; $display("[TB] FAIL rst_lo: got %h want 8000", lo_thresh); end
        checks++; if (hi_thresh !== 16'h7FFF) begin errors++; $display("[TB] FAIL rst_hi: got %h want 7fff", hi_thresh); end
        checks++; if (pointer_reg !== 2'd0) begin errors++; $display("[TB] FAIL rst_pointer: got %0d want 0", pointer_reg); end
        checks++; if (cfg_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_write: got %b want 0", cfg_write); end
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d want 0", state_check); end
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("[TB] FAIL rst_sda: got %b want 1", sda_bus); end
    endtask

    task automatic test_config_write();
        int p0 = cfg_pulses;
        int h0 = cfg_high;
        bus_start();
        applyStimulus(8'h90, 1'b0, "cfg_addr_ack");
        applyStimulus(8'h01, 1'b0, "cfg_ptr_ack");
        applyStimulus(8'h84, 1'b0, "cfg_msb_ack");
        applyStimulus(8'h83, 1'b0, "cfg_lsb_ack");
        bus_stop();
        checks++; if (config_reg !== 16'h8483) begin errors++; $display("[TB] FAIL cfg_value: got %h want 8483", config_reg); end
        checks++; if (cfg_pulses - p0 !== 1) begin errors++; $display("[TB] FAIL cfg_pulses: got %0d want 1", cfg_pulses - p0); end
        checks++; if (cfg_high - h0 !== 1) begin errors++; $display("[TB] FAIL cfg_width: got %0d want 1", cfg_high - h0); end
        checks++; if (pointer_reg !== 2'd1) begin errors++; $display("[TB] FAIL cfg_pointer: got %0d want 1", pointer_reg); end
        checks++; if (lo_thresh !== 16'h8000) begin errors++; $display("[TB] FAIL cfg_lo_untouched: got %h want 8000", lo_thresh); end
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL cfg_idle: got %0d want 0", state_check); end
    endtask

    task automatic test_conv_read();
        logic [7:0] d, e;
        @(negedge clk); conv_data = 16'h1234; conv_valid = 1'b1;
        @(negedge clk); conv_valid = 1'b0;
        bus_start();
        applyStimulus(8'h90, 1'b0, "conv_waddr_ack");
        applyStimulus(8'h00, 1'b0, "conv_ptr_ack");
        bus_rstart();
        applyStimulus(8'h91, 1'b0, "conv_raddr_ack");
        expq.push_back(8'h12);
        expq.push_back(8'h34);
        read_byte(1'b0, d); e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL conv_msb: got %h want %h", d, e); end
        read_byte(1'b1, d); e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL conv_lsb: got %h want %h", d, e); end
        checks++; if (state_check !== 4'd9) begin errors++; $display("[TB] FAIL conv_ignore: got %0d want 9", state_check); end
        bus_stop();
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL conv_idle: got %0d want 0", state_check); end
    endtask

    task automatic test_wrong_addr();
        int p0 = cfg_pulses;
        pull_seen = 1'b0;
        bus_start();
        applyStimulus(8'h92, 1'b1, "wrong_addr_nack");
        applyStimulus(8'h01, 1'b1, "wrong_ptr_nack");
        applyStimulus(8'h12, 1'b1, "wrong_data_nack");
        checks++; if (state_check !== 4'd9) begin errors++; $display("[TB] FAIL wrong_ignore: got %0d want 9", state_check); end
        bus_stop();
        checks++; if (pull_seen !== 1'b0) begin errors++; $display("[TB] FAIL wrong_sda_pulled: got %b want 0", pull_seen); end
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL wrong_idle: got %0d want 0", state_check); end
        checks++; if (config_reg !== 16'h8483) begin errors++; $display("[TB] FAIL wrong_config: got %h want 8483", config_reg); end
        checks++; if (pointer_reg !== 2'd0) begin errors++; $display("[TB] FAIL wrong_pointer: got %0d want 0", pointer_reg); end
        checks++; if (cfg_pulses !== p0) begin errors++; $display("[TB] FAIL wrong_pulses: got %0d want %0d", cfg_pulses, p0); end
    endtask

    task automatic test_tear_free();
        logic [7:0] d, e;
        @(negedge clk); conv_data = 16'hABCD; conv_valid = 1'b1;
        @(negedge clk); conv_valid = 1'b0;
        bus_start();
        applyStimulus(8'h91, 1'b0, "tear_addr_ack");
        expq.push_back(8'hAB);
        expq.push_back(8'hCD);
        fork
            read_byte(1'b0, d);
            begin
                repeat (12 * Q) @(negedge clk);
                conv_data = 16'h5555; conv_valid = 1'b1;
                @(negedge clk); conv_valid = 1'b0;
            end
        join
        e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL tear_msb: got %h want %h", d, e); end
        read_byte(1'b1, d); e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL tear_lsb: got %h want %h", d, e); end
        bus_stop();
        bus_start();
        applyStimulus(8'h91, 1'b0, "tear2_addr_ack");
        expq.push_back(8'h55);
        expq.push_back(8'h55);
        read_byte(1'b0, d); e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL tear2_msb: got %h want %h", d, e); end
        read_byte(1'b1, d); e = expq.pop_front();
        checks++; if (d !== e) begin errors++; $display("[TB] FAIL tear2_lsb: got %h want %h", d, e); end
        bus_stop();
    endtask

    task automatic test_abort_write();
        int p0 = cfg_pulses;
        bus_start();
        applyStimulus(8'h90, 1'b0, "abort_addr_ack");
        applyStimulus(8'h03, 1'b0, "abort_ptr_ack");
        applyStimulus(8'h12, 1'b0, "abort_msb_ack");
        bus_stop();
        checks++; if (hi_thresh !== 16'h7FFF) begin errors++; $display("[TB] FAIL abort_hi: got %h want 7fff", hi_thresh); end
        checks++; if (cfg_pulses !== p0) begin errors++; $display("[TB] FAIL abort_pulses: got %0d want %0d", cfg_pulses, p0); end
        checks++; if (pointer_reg !== 2'd3) begin errors++; $display("[TB] FAIL abort_pointer: got %0d want 3", pointer_reg); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        logic [7:0] wr[6] = '{8'h90, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        logic       nk[3] = '{1'b0, 1'b0, 1'b1};
        int p0 = cfg_pulses;
        bus_start();
        foreach (wr[i]) applyStimulus(wr[i], 1'b0, "b2b_lo_ack");
        bus_stop();
        checks++; if (lo_thresh !== 16'h3344) begin errors++; $display("[TB] FAIL b2b_lo: got %h want 3344", lo_thresh); end
        checks++; if (cfg_pulses - p0 !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d want 2", cfg_pulses - p0); end
        p0 = cfg_pulses;
        bus_start();
        applyStimulus(8'h90, 1'b0, "ro_addr_ack");
        applyStimulus(8'h00, 1'b0, "ro_ptr_ack");
        applyStimulus(8'hBE, 1'b0, "ro_msb_ack");
        applyStimulus(8'hEF, 1'b0, "ro_lsb_ack");
        bus_stop();
        checks++; if (cfg_pulses !== p0) begin errors++; $display("[TB] FAIL ro_pulses: got %0d want %0d", cfg_pulses, p0); end
        bus_start();
        applyStimulus(8'h90, 1'b0, "rd_lo_waddr_ack");
        applyStimulus(8'h02, 1'b0, "rd_lo_ptr_ack");
        bus_rstart();
        applyStimulus(8'h91, 1'b0, "rd_lo_raddr_ack");
        expq.push_back(8'h33);
        expq.push_back(8'h44);
        expq.push_back(8'h33);
        for (int i = 0; i < 3; i++) begin
            read_byte(nk[i], d);
            e = expq.pop_front();
            checks++; if (d !== e) begin errors++; $display("[TB] FAIL rd_lo_byte%0d: got %h want %h", i, d, e); end
        end
        bus_stop();
    endtask

    task automatic test_reset_mid_read();
        bus_start();
        applyStimulus(8'h91, 1'b0, "rmr_addr_ack");
        master_low = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sda_bus !== 1'b0) begin errors++; $display("[TB] FAIL rmr_drive0: got %b want 0", sda_bus); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("[TB] FAIL rmr_sda_release: got %b want 1", sda_bus); end
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL rmr_state: got %0d want 0", state_check); end
        checks++; if (config_reg !== 16'h8583) begin errors++; $display("[TB] FAIL rmr_config: got %h want 8583", config_reg); end
        checks++; if (lo_thresh !== 16'h8000) begin errors++; $display("[TB] FAIL rmr_lo: got %h want 8000", lo_thresh); end
        checks++; if (hi_thresh !== 16'h7FFF) begin errors++; $display("[TB] FAIL rmr_hi: got %h want 7fff", hi_thresh); end
        checks++; if (pointer_reg !== 2'd0) begin errors++; $display("[TB] FAIL rmr_pointer: got %0d want 0", pointer_reg); end
        checks++; if (cfg_write !== 1'b0) begin errors++; $display("[TB] FAIL rmr_cfg_write: got %b want 0", cfg_write); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_stop();
        checks++; if (state_check !== 4'd0) begin errors++; $display("[TB] FAIL rmr_idle: got %0d want 0", state_check); end
    endtask

    initial begin
        rst_n      = 1'b0;
        scl        = 1'b1;
        master_low = 1'b0;
        conv_data  = 16'd0;
        conv_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_config_write();
        test_conv_read();
        test_wrong_addr();
        test_tear_free();
        test_abort_write();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
